// File: rtl/ecc_apb_pkg.sv
// ecc_apb_pkg: register map, enums and Hamming SEC-DED helpers for the ECC engine
package ecc_apb_pkg;

   localparam logic [2:0] REG_CTRL   = 3'd0;
   localparam logic [2:0] REG_DATA   = 3'd1;
   localparam logic [2:0] REG_WIDTH  = 3'd2;
   localparam logic [2:0] REG_NOISE  = 3'd3;
   localparam logic [2:0] REG_STATUS = 3'd4;
   localparam logic [2:0] REG_RESULT = 3'd5;
   localparam logic [2:0] REG_RESERR = 3'd6;

   typedef enum logic [1:0] {MODE_ENC = 2'd0, MODE_DEC = 2'd1, MODE_FULL = 2'd2, MODE_NOP = 2'd3} mode_e;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_e;
   typedef enum logic [1:0] {W_8 = 2'd0, W_16 = 2'd1, W_32 = 2'd2, W_32B = 2'd3} width_e;

   typedef struct packed {
      logic [1:0]  err;
      logic [31:0] data;
   } result_t;

   function automatic int cw_n(input width_e w);
      return (w == W_8) ? 8 : (w == W_16) ? 16 : 32;
   endfunction

   function automatic int cw_k(input width_e w);
      return (w == W_8) ? 4 : (w == W_16) ? 11 : 26;
   endfunction

   // parity bits below the overall parity bit
   function automatic int cw_p(input width_e w);
      return cw_n(w) - cw_k(w) - 1;
   endfunction

   function automatic logic [31:0] low_mask(input int n);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 32; i++) m[i] = (i < n);
      return m;
   endfunction

   // Hamming position of data bit i: the i-th integer >= 3 that is not a power of two
   function automatic logic [4:0] h_pos(input int i);
      int c;
      logic [4:0] r;
      c = 0;
      r = '0;
      for (int v = 3; v < 32; v++)
         if ((v & (v - 1)) != 0) begin
            if (c == i) r = 5'(v);
            c++;
         end
      return r;
   endfunction

   // parity bit j collects every data bit whose Hamming position has bit j set
   function automatic logic [4:0] hamming_par(input logic [25:0] d, input int k);
      logic [4:0] p;
      p = '0;
      for (int i = 0; i < 26; i++)
         if (i < k) p = p ^ (h_pos(i) & {5{d[i]}});
      return p;
   endfunction

   function automatic logic [31:0] ecc_encode(input logic [31:0] d, input width_e w);
      logic [31:0] cw;
      int k;
      k = cw_k(w);
      cw = d & low_mask(k);
      cw = cw | ({27'd0, hamming_par(d[25:0], k)} << k);
      cw = cw | ({31'd0, ^cw} << (cw_n(w) - 1));
      return cw;
   endfunction

   function automatic result_t ecc_decode(input logic [31:0] cw_in, input width_e w);
      logic [31:0] cw, d;
      logic [4:0] syn;
      int k;
      result_t r;
      k = cw_k(w);
      cw = cw_in & low_mask(cw_n(w));
      d = cw & low_mask(k);
      syn = hamming_par(d[25:0], k) ^ 5'((cw >> k) & low_mask(cw_p(w)));
      r.err = 2'b00;
      if (^cw) begin
         r.err = 2'b01;
         for (int i = 0; i < 26; i++)
            if (i < k && syn != 5'd0 && h_pos(i) == syn) d[i] = ~d[i];
      end else if (syn != 5'd0) begin
         r.err = 2'b10;
      end
      r.data = d;
      return r;
   endfunction

endpackage

// File: rtl/ecc_apb_engine_if.sv
// ecc_apb_engine_if: APB3 bus bundle (no PREADY, zero wait states)
interface ecc_apb_engine_if #(
   parameter int AMBA_ADDR_WIDTH = 20,
   parameter int AMBA_WORD       = 32
);
   logic [AMBA_ADDR_WIDTH-1:0] PADDR;
   logic [AMBA_WORD-1:0]       PWDATA;
   logic [AMBA_WORD-1:0]       PRDATA;
   logic                       PENABLE;
   logic                       PSEL;
   logic                       PWRITE;

   modport master (output PADDR, PWDATA, PENABLE, PSEL, PWRITE, input PRDATA);
   modport slave  (input PADDR, PWDATA, PENABLE, PSEL, PWRITE, output PRDATA);
endinterface

// File: rtl/ecc_result_fifo.sv
// ecc_result_fifo: result queue; a push into a full queue is dropped unless a pop frees a slot
module ecc_result_fifo
   import ecc_apb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    i_push,
   input  logic    i_pop,
   input  result_t i_din,
   output result_t o_dout,
   output logic    o_full,
   output logic    o_empty,
   output logic    o_drop
);
   localparam int AW = $clog2(DEPTH);

   result_t       r_mem [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0]   r_cnt;
   logic          w_wr, w_rd;

   assign o_full  = r_cnt == (AW+1)'(DEPTH);
   assign o_empty = r_cnt == '0;
   assign w_rd    = i_pop & ~o_empty;
   assign w_wr    = i_push & (~o_full | w_rd);
   assign o_drop  = i_push & ~w_wr;
   assign o_dout  = r_mem[r_rp];

   // storage, pointers and occupancy
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_wr) begin
            r_mem[r_wp] <= i_din;
            r_wp        <= r_wp + 1'b1;
         end
         if (w_rd) r_rp <= r_rp + 1'b1;
         r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
      end
endmodule

// File: rtl/ecc_apb_engine.sv
// ecc_apb_engine: APB3 slave running SEC-DED encode/decode/noisy round-trip at 8/16/32-bit widths
module ecc_apb_engine
   import ecc_apb_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int AMBA_ADDR_WIDTH = 20,
   parameter int AMBA_WORD       = 32,
   parameter int RES_DEPTH       = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   ecc_apb_engine_if.slave       apb,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  operation_done,
   output logic [1:0]            num_of_errors
);
   state_e                r_state, w_next;
   mode_e                 r_ctrl, r_op_mode;
   width_e                r_width, r_op_width;
   logic [AMBA_WORD-1:0]  r_data_in, r_noise, r_op_data, r_op_noise, w_rdata;
   logic [DATA_WIDTH-1:0] r_data_out;
   logic [1:0]            r_err;
   logic                  r_overflow;
   logic [2:0]            w_addr;
   logic                  w_access, w_wr, w_rd, w_start, w_busy;
   logic                  w_push, w_pop, w_full, w_empty, w_drop;
   logic [31:0]           w_cw;
   result_t               w_res, w_head;
   logic                  w_unused;

   assign w_unused = ^{apb.PADDR[AMBA_ADDR_WIDTH-1:5], apb.PADDR[1:0]};
   assign w_addr   = apb.PADDR[4:2];
   assign w_access = apb.PSEL & apb.PENABLE;
   assign w_busy   = r_state != S_IDLE;
   assign w_wr     = w_access & apb.PWRITE & ~w_busy;
   assign w_rd     = w_access & ~apb.PWRITE;
   assign w_start  = w_wr && w_addr == REG_CTRL && apb.PWDATA[1:0] != MODE_NOP;
   assign w_push   = r_state == S_DONE;
   assign w_pop    = w_rd && w_addr == REG_RESULT && !w_empty;

   assign data_out       = r_data_out;
   assign num_of_errors  = r_err;
   assign operation_done = r_state == S_DONE;

   // FSM state register
   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= S_IDLE;
      else r_state <= w_next;

   // FSM next state: a start launches a fixed CALC -> DONE -> IDLE sequence
   always_comb begin
      w_next = r_state;
      w_next = (r_state == S_IDLE) ? (w_start ? S_CALC : S_IDLE) :
               (r_state == S_CALC) ? S_DONE : S_IDLE;
   end

   // software-visible registers; writes are ignored while an operation is in flight
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_ctrl    <= MODE_ENC;
         r_data_in <= '0;
         r_width   <= W_8;
         r_noise   <= '0;
      end else if (w_wr) begin
         if (w_addr == REG_CTRL)  r_ctrl    <= mode_e'(apb.PWDATA[1:0]);
         if (w_addr == REG_DATA)  r_data_in <= apb.PWDATA;
         if (w_addr == REG_WIDTH) r_width   <= width_e'(apb.PWDATA[1:0]);
         if (w_addr == REG_NOISE) r_noise   <= apb.PWDATA;
      end

   // operand snapshot taken at the launching CTRL write
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_op_mode  <= MODE_ENC;
         r_op_width <= W_8;
         r_op_data  <= '0;
         r_op_noise <= '0;
      end else if (w_start) begin
         r_op_mode  <= mode_e'(apb.PWDATA[1:0]);
         r_op_width <= r_width;
         r_op_data  <= r_data_in;
         r_op_noise <= r_noise;
      end

   // codec datapath evaluated from the snapshot during CALC
   always_comb begin
      w_cw  = ecc_encode(r_op_data, r_op_width);
      w_res = (r_op_mode == MODE_DEC)  ? ecc_decode(r_op_data, r_op_width) :
              (r_op_mode == MODE_FULL) ? ecc_decode(w_cw ^ r_op_noise, r_op_width) :
                                         result_t'({2'b00, w_cw});
   end

   // result outputs become visible in DONE
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_data_out <= '0;
         r_err      <= 2'b00;
      end else if (r_state == S_CALC) begin
         r_data_out <= w_res.data;
         r_err      <= w_res.err;
      end

   // sticky record of any result lost to a full queue
   always_ff @(posedge clk or posedge rst)
      if (rst) r_overflow <= 1'b0;
      else if (w_drop) r_overflow <= 1'b1;

   ecc_result_fifo #(.DEPTH(RES_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_din   (result_t'({r_err, r_data_out})),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_drop  (w_drop)
   );

   // read mux; the queue head reads as zero when nothing is queued
   always_comb begin
      w_rdata = '0;
      case (w_addr)
         REG_CTRL:   w_rdata = {30'd0, r_ctrl};
         REG_DATA:   w_rdata = r_data_in;
         REG_WIDTH:  w_rdata = {30'd0, r_width};
         REG_NOISE:  w_rdata = r_noise;
         REG_STATUS: w_rdata = {28'd0, r_overflow, w_empty, w_full, w_busy};
         REG_RESULT: w_rdata = w_empty ? '0 : w_head.data;
         REG_RESERR: w_rdata = w_empty ? '0 : {30'd0, w_head.err};
         default:    w_rdata = '0;
      endcase
      apb.PRDATA = w_rd ? w_rdata : '0;
   end
endmodule

// File: tb/tb_ecc_apb_engine.sv
// tb_ecc_apb_engine: directed and random checks of the ECC engine against a positional Hamming model
module tb_ecc_apb_engine;
   localparam int DEPTH = 4;
   localparam logic [4:0] A_CTRL = 5'h00, A_DATA = 5'h04, A_WIDTH = 5'h08, A_NOISE = 5'h0C;
   localparam logic [4:0] A_STATUS = 5'h10, A_RESULT = 5'h14, A_RESERR = 5'h18;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] data_out;
   logic        operation_done;
   logic [1:0]  num_of_errors;
   int          n_vec = 0;
   int          n_err = 0;
   logic [33:0] q[$];
   logic [33:0] last_exp = '0;
   logic [33:0] exp_d;
   logic [31:0] r;
   bit          m_ovf = 0;

   ecc_apb_engine_if #(.AMBA_ADDR_WIDTH(20), .AMBA_WORD(32)) apb ();

   ecc_apb_engine #(.DATA_WIDTH(32), .AMBA_ADDR_WIDTH(20), .AMBA_WORD(32), .RES_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .apb            (apb),
      .data_out       (data_out),
      .operation_done (operation_done),
      .num_of_errors  (num_of_errors)
   );

   always #5 clk = ~clk;

   function automatic int hpos(input int i);
      int c = 0;
      for (int v = 3; v < 64; v++)
         if ((v & (v - 1)) != 0) begin
            if (c == i) return v;
            c++;
         end
      return 0;
   endfunction

   function automatic int nbits(input int w);
      return (w == 0) ? 8 : (w == 1) ? 16 : 32;
   endfunction

   function automatic int kbits(input int w);
      return (w == 0) ? 4 : (w == 1) ? 11 : 26;
   endfunction

   function automatic logic [31:0] m_enc(input int w, input logic [31:0] d);
      int n, k;
      bit pos[64];
      bit b;
      logic [31:0] cw;
      n = nbits(w);
      k = kbits(w);
      foreach (pos[q_]) pos[q_] = 0;
      cw = '0;
      for (int i = 0; i < k; i++) begin
         pos[hpos(i)] = d[i];
         cw[i] = d[i];
      end
      for (int j = 0; j < n - k - 1; j++) begin
         b = 0;
         for (int p = 1; p < n; p++) if (p[j]) b ^= pos[p];
         cw[k + j] = b;
      end
      cw[n - 1] = ^cw;
      return cw;
   endfunction

   function automatic logic [33:0] m_dec(input int w, input logic [31:0] cw_in);
      int n, k, syn;
      bit pos[64];
      logic [31:0] cw, d;
      logic [1:0] e;
      n = nbits(w);
      k = kbits(w);
      cw = '0;
      for (int p = 0; p < n; p++) cw[p] = cw_in[p];
      foreach (pos[q_]) pos[q_] = 0;
      for (int i = 0; i < k; i++) pos[hpos(i)] = cw[i];
      for (int j = 0; j < n - k - 1; j++) pos[1 << j] = cw[k + j];
      syn = 0;
      for (int p = 1; p < n; p++) if (pos[p]) syn ^= p;
      e = 2'd0;
      if (^cw) begin
         e = 2'd1;
         if (syn != 0) pos[syn] = !pos[syn];
      end else if (syn != 0) begin
         e = 2'd2;
      end
      d = '0;
      for (int i = 0; i < k; i++) d[i] = pos[hpos(i)];
      return {e, d};
   endfunction

   function automatic logic [31:0] m_status();
      return {28'd0, m_ovf, q.size() == 0, q.size() == DEPTH, 1'b0};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
      end
   endtask

   task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = 20'(a); apb.PWDATA = d;
      @(negedge clk);
      apb.PENABLE = 1'b1;
      @(negedge clk);
      apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
   endtask

   task automatic apb_read(input logic [4:0] a, output logic [31:0] d);
      @(negedge clk);
      apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = 20'(a);
      @(negedge clk);
      apb.PENABLE = 1'b1;
      #1 d = apb.PRDATA;
      @(negedge clk);
      apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
   endtask

   task automatic run_op(input int w, input logic [31:0] d, input logic [31:0] nz, input int mode);
      logic [33:0] e;
      e = (mode == 0) ? {2'b00, m_enc(w, d)} : (mode == 1) ? m_dec(w, d) : m_dec(w, m_enc(w, d) ^ nz);
      apb_write(A_WIDTH, 32'(w));
      apb_write(A_DATA, d);
      apb_write(A_NOISE, nz);
      apb_write(A_CTRL, 32'(mode));
      check("calc_no_done", 32'(operation_done), 32'd0);
      @(posedge clk);
      #1;
      check("done_pulse", 32'(operation_done), 32'd1);
      check("data_out", data_out, e[31:0]);
      check("num_of_errors", 32'(num_of_errors), 32'(e[33:32]));
      if (q.size() < DEPTH) q.push_back(e);
      else m_ovf = 1;
      last_exp = e;
      @(posedge clk);
      #1;
      check("done_one_cycle", 32'(operation_done), 32'd0);
   endtask

   initial begin
      apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = '0; apb.PWDATA = '0;
      repeat (2) @(negedge clk);
      check("rst_done", 32'(operation_done), 32'd0);
      check("rst_data_out", data_out, 32'd0);
      check("rst_errors", 32'(num_of_errors), 32'd0);
      check("rst_prdata", apb.PRDATA, 32'd0);
      rst = 1'b0;
      apb_read(A_STATUS, r);
      check("status_after_reset", r, m_status());

      run_op(0, 32'hB, 32'h0, 0);
      check("enc_0xB_literal", data_out, 32'h1B);
      run_op(0, 32'hB, 32'h1, 2);
      check("full_single_literal", {30'd0, num_of_errors}, 32'd1);
      run_op(0, 32'hB, 32'h3, 2);
      check("full_double_literal", {30'd0, num_of_errors}, 32'd2);

      apb_write(A_DATA, 32'h1B);
      apb_write(A_CTRL, 32'd1);
      exp_d = m_dec(0, 32'h1B);
      check("dec_calc_no_done", 32'(operation_done), 32'd0);
      apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = 20'(A_CTRL); apb.PWDATA = 32'd2;
      @(negedge clk);
      check("dec_done", 32'(operation_done), 32'd1);
      check("dec_data_out", data_out, 32'hB);
      check("dec_errors", 32'(num_of_errors), 32'(exp_d[33:32]));
      q.push_back(exp_d);
      last_exp = exp_d;
      apb.PENABLE = 1'b1;
      @(negedge clk);
      apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
      check("busy_done_end", 32'(operation_done), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("no_second_pulse", 32'(operation_done), 32'd0);
      end

      apb_read(A_STATUS, r);
      check("status_full", r, m_status());
      run_op(0, 32'h5, 32'h0, 0);
      apb_read(A_STATUS, r);
      check("status_overflow", r, m_status());
      apb_read(A_RESERR, r);
      check("peek_err", r, 32'(q[0][33:32]));
      while (q.size() > 0) begin
         exp_d = q.pop_front();
         apb_read(A_RESULT, r);
         check("fifo_order", r, exp_d[31:0]);
      end
      apb_read(A_RESULT, r);
      check("result_empty_zero", r, 32'd0);
      apb_read(A_STATUS, r);
      check("status_drained", r, m_status());

      for (int it = 0; it < 40; it++) begin
         int w, mode, n;
         logic [31:0] d, nz;
         w = int'($urandom_range(0, 3));
         n = nbits(w);
         mode = int'($urandom_range(0, 2));
         d = $urandom;
         case ($urandom_range(0, 3))
            0: nz = 32'd0;
            1: nz = 32'd1 << $urandom_range(0, n - 1);
            2: nz = (32'd1 << $urandom_range(0, n - 1)) | (32'd1 << $urandom_range(0, n - 1));
            default: nz = $urandom;
         endcase
         if (mode == 1 && $urandom_range(0, 1) == 1) d = m_enc(w, d) ^ nz;
         run_op(w, d, nz, mode);
         exp_d = q.pop_front();
         apb_read(A_RESERR, r);
         check("rand_result_err", r, 32'(exp_d[33:32]));
         apb_read(A_RESULT, r);
         check("rand_result", r, exp_d[31:0]);
      end

      apb_write(A_CTRL, 32'd3);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("nop_no_done", 32'(operation_done), 32'd0);
      end
      check("nop_data_kept", data_out, last_exp[31:0]);

      run_op(0, 32'hB, 32'h0, 0);
      apb_write(A_CTRL, 32'd0);
      rst = 1'b1;
      #1;
      check("midop_rst_data", data_out, 32'd0);
      check("midop_rst_err", 32'(num_of_errors), 32'd0);
      check("midop_rst_done", 32'(operation_done), 32'd0);
      check("midop_rst_prdata", apb.PRDATA, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      m_ovf = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_no_done", 32'(operation_done), 32'd0);
      end
      apb_read(A_STATUS, r);
      check("post_rst_status", r, m_status());
      apb_read(A_RESULT, r);
      check("post_rst_result", r, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
